// File: rtl/lot_pkg.sv
// Shared types and helpers for the parking-lot occupancy counter.
package lot_pkg;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    AVAILABLE = 2'd1,
    NEAR_FULL = 2'd2,
    FULL      = 2'd3
  } lot_status_e;

  // A margin at or above capacity makes cap-margin <= 0, so every non-empty,
  // non-full count lands in NEAR_FULL without a special case.
  function automatic lot_status_e status_of(input int cnt, input int cap, input int margin);
    lot_status_e st;
    if (cnt <= 0) begin
      st = EMPTY;
    end else if (cnt >= cap) begin
      st = FULL;
    end else if (cnt >= cap - margin) begin
      st = NEAR_FULL;
    end else begin
      st = AVAILABLE;
    end
    return st;
  endfunction

endpackage

// File: rtl/gate_popcount.sv
// Combinational ones-count of the per-gate pulse vector.
module gate_popcount #(
  parameter  int N = 2,
  localparam int W = $clog2(N + 1)
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] ones
);

  // Sum the individual gate pulses
  always_comb begin
    ones = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      ones = ones + W'(bits[i]);
    end
  end

endmodule

// File: rtl/lot_occupancy_counter.sv
// Saturating multi-gate parking-lot occupancy counter with status, refusal and underflow reporting.
// Optional peak tracking is enabled by defining OCC_PEAK_TRACK_EN.
module lot_occupancy_counter
  import lot_pkg::*;
#(
  parameter  int CAPACITY    = 25,
  parameter  int NUM_GATES   = 2,
  parameter  int NEAR_MARGIN = 3,
  parameter  int REJ_W       = 8,
  localparam int CW          = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] enter,
  input  logic [NUM_GATES-1:0] exit,
  input  logic                 clear,
  input  logic                 err_clr,
  output logic [CW-1:0]        count,
  output lot_status_e          status,
  output logic                 overflow,
  output logic [REJ_W-1:0]     rejected_total,
  output logic                 err_underflow
`ifdef OCC_PEAK_TRACK_EN
  ,
  output logic [CW-1:0]        peak
`endif
);

  localparam int PW = $clog2(NUM_GATES + 1);
  localparam int NW = CW + PW + 1;
  localparam int SW = ((REJ_W > NW) ? REJ_W : NW) + 1;
  localparam logic signed [NW-1:0] CAP_S   = NW'(CAPACITY);
  localparam logic        [SW-1:0] REJ_MAX = {{(SW - REJ_W){1'b0}}, {REJ_W{1'b1}}};

  logic [PW-1:0]        enter_cnt_s;
  logic [PW-1:0]        exit_cnt_s;
  logic signed [NW-1:0] net_s;
  logic [NW-1:0]        excess_s;
  logic [SW-1:0]        rej_sum_s;
  logic [CW-1:0]        next_count_s;
  logic [REJ_W-1:0]     next_rej_s;
  logic                 ovf_s;
  logic                 unf_s;
  logic                 next_err_s;
  lot_status_e          status_next_s;

  logic [CW-1:0]        count_r;
  lot_status_e          status_r;
  logic                 overflow_r;
  logic [REJ_W-1:0]     rej_r;
  logic                 err_r;

  gate_popcount #(.N(NUM_GATES)) u_enter_cnt (.bits(enter), .ones(enter_cnt_s));
  gate_popcount #(.N(NUM_GATES)) u_exit_cnt  (.bits(exit),  .ones(exit_cnt_s));

  // Next-state: signed net count, clamp, refusal accounting and status decode
  always_comb begin
    net_s = $signed({{(NW - CW){1'b0}}, count_r})
          + $signed({{(NW - PW){1'b0}}, enter_cnt_s})
          - $signed({{(NW - PW){1'b0}}, exit_cnt_s});
    excess_s     = net_s - CAP_S;
    rej_sum_s    = {{(SW - REJ_W){1'b0}}, rej_r} + {{(SW - NW){1'b0}}, excess_s};
    next_count_s = count_r;
    next_rej_s   = rej_r;
    ovf_s        = 1'b0;
    unf_s        = 1'b0;
    if (clear) begin
      next_count_s = {CW{1'b0}};
    end else if (net_s > CAP_S) begin
      next_count_s = CW'(CAPACITY);
      ovf_s        = 1'b1;
      if (rej_sum_s > REJ_MAX) begin
        next_rej_s = {REJ_W{1'b1}};
      end else begin
        next_rej_s = rej_sum_s[REJ_W-1:0];
      end
    end else if (net_s[NW-1]) begin
      next_count_s = {CW{1'b0}};
      unf_s        = 1'b1;
    end else begin
      next_count_s = net_s[CW-1:0];
    end
    // err_clr wins over a simultaneous underflow
    if (err_clr) begin
      next_err_s = 1'b0;
    end else if (unf_s) begin
      next_err_s = 1'b1;
    end else begin
      next_err_s = err_r;
    end
    status_next_s = status_of(int'(next_count_s), CAPACITY, NEAR_MARGIN);
  end

  // Occupancy, status and error state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r    <= {CW{1'b0}};
      status_r   <= EMPTY;
      overflow_r <= 1'b0;
      rej_r      <= {REJ_W{1'b0}};
      err_r      <= 1'b0;
    end else begin
      count_r    <= next_count_s;
      status_r   <= status_next_s;
      overflow_r <= ovf_s;
      rej_r      <= next_rej_s;
      err_r      <= next_err_s;
    end
  end

  assign count          = count_r;
  assign status         = status_r;
  assign overflow       = overflow_r;
  assign rejected_total = rej_r;
  assign err_underflow  = err_r;

`ifdef OCC_PEAK_TRACK_EN
  logic [CW-1:0] peak_r;

  // High-water mark of the occupancy since reset or clear
  always_ff @(posedge clk) begin
    if (reset) begin
      peak_r <= {CW{1'b0}};
    end else if (clear) begin
      peak_r <= {CW{1'b0}};
    end else if (next_count_s > peak_r) begin
      peak_r <= next_count_s;
    end else begin
      peak_r <= peak_r;
    end
  end

  assign peak = peak_r;
`endif

endmodule

// File: tb/tb_lot_occupancy_counter.sv
// Self-checking bench for lot_occupancy_counter: directed scenarios plus randomized traffic
// against an arithmetic reference model. Peak checks are active when OCC_PEAK_TRACK_EN is defined.
module tb_lot_occupancy_counter;
  import lot_pkg::*;

  localparam int CAP    = 25;
  localparam int NG     = 2;
  localparam int MARGIN = 3;
  localparam int RW     = 8;
  localparam int REJ_SAT = 255;

  logic          clk;
  logic          reset;
  logic [NG-1:0] enter;
  logic [NG-1:0] exit;
  logic          clear;
  logic          err_clr;
  logic [4:0]    count;
  lot_status_e   status;
  logic          overflow;
  logic [RW-1:0] rejected_total;
  logic          err_underflow;
`ifdef OCC_PEAK_TRACK_EN
  logic [4:0]    peak;
`endif

  int n_checks;
  int n_errors;

  int m_count;
  int m_rej;
  int m_peak;
  bit m_err;
  bit m_ovf;

  lot_occupancy_counter #(
    .CAPACITY(CAP), .NUM_GATES(NG), .NEAR_MARGIN(MARGIN), .REJ_W(RW)
  ) dut (
`ifdef OCC_PEAK_TRACK_EN
    .peak(peak),
`endif
    .clk(clk), .reset(reset), .enter(enter), .exit(exit), .clear(clear),
    .err_clr(err_clr), .count(count), .status(status), .overflow(overflow),
    .rejected_total(rejected_total), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_status(input int c);
    if (c == 0)                return 2'd0;
    else if (c == CAP)         return 2'd3;
    else if (CAP - c <= MARGIN) return 2'd2;
    else                       return 2'd1;
  endfunction

  // Drive one cycle of inputs, advance the reference model, settle past the edge
  task automatic step(input logic [1:0] e, input logic [1:0] x, input logic c,
                      input logic ec, input logic r);
    int net;
    enter = e; exit = x; clear = c; err_clr = ec; reset = r;
    @(posedge clk);
    m_ovf = 1'b0;
    if (r) begin
      m_count = 0; m_rej = 0; m_err = 1'b0; m_peak = 0;
    end else begin
      net = m_count + $countones(e) - $countones(x);
      if (c) begin
        m_count = 0; m_peak = 0;
      end else if (net > CAP) begin
        m_count = CAP; m_ovf = 1'b1;
        m_rej = (m_rej + net - CAP > REJ_SAT) ? REJ_SAT : m_rej + net - CAP;
      end else if (net < 0) begin
        m_count = 0;
        if (!ec) m_err = 1'b1;
      end else begin
        m_count = net;
      end
      if (ec) m_err = 1'b0;
      if (m_count > m_peak) m_peak = m_count;
    end
    #1;
  endtask

  task automatic test_reset();
    step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (count !== 5'd0 || status !== EMPTY || overflow !== 1'b0 ||
        rejected_total !== 8'd0 || err_underflow !== 1'b0) begin
      n_errors++;
      $display("FAIL reset: count=%0d status=%0d ovf=%0b rej=%0d err=%0b, required 0/0/0/0/0",
               count, status, overflow, rejected_total, err_underflow);
    end
`ifdef OCC_PEAK_TRACK_EN
    n_checks++;
    if (peak !== 5'd0) begin
      n_errors++; $display("FAIL reset_peak: got %0d required 0", peak);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 13; i++) begin
      step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (count !== 5'((2 * i > CAP) ? CAP : 2 * i)) begin
        n_errors++; $display("FAIL fill_count[%0d]: got %0d required %0d", i, count, (2 * i > CAP) ? CAP : 2 * i);
      end
      n_checks++;
      if (overflow !== (i == 13)) begin
        n_errors++; $display("FAIL fill_ovf[%0d]: got %0b required %0b", i, overflow, i == 13);
      end
      n_checks++;
      if (status !== exp_status(m_count)) begin
        n_errors++; $display("FAIL fill_status[%0d]: got %0d required %0d", i, status, exp_status(m_count));
      end
    end
    n_checks++;
    if (rejected_total !== 8'd1 || status !== FULL) begin
      n_errors++; $display("FAIL fill_final: rej=%0d status=%0d required 1/3", rejected_total, status);
    end
  endtask

  task automatic test_cancel_at_full();
    step(2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd25 || overflow !== 1'b0 || status !== FULL) begin
      n_errors++; $display("FAIL cancel_full: count=%0d ovf=%0b status=%0d required 25/0/3", count, overflow, status);
    end
    step(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd23 || status !== NEAR_FULL) begin
      n_errors++; $display("FAIL exit_from_full: count=%0d status=%0d required 23/2", count, status);
    end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 11; i++) step(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd1 || status !== AVAILABLE || err_underflow !== 1'b0) begin
      n_errors++; $display("FAIL drain_to_one: count=%0d status=%0d err=%0b required 1/1/0", count, status, err_underflow);
    end
    step(2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd0 || status !== EMPTY || err_underflow !== 1'b1) begin
      n_errors++; $display("FAIL underflow: count=%0d status=%0d err=%0b required 0/0/1", count, status, err_underflow);
    end
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (err_underflow !== 1'b1) begin
      n_errors++; $display("FAIL underflow_sticky: got %0b required 1", err_underflow);
    end
    step(2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_errors++; $display("FAIL err_clr: got %0b required 0", err_underflow);
    end
    step(2'b00, 2'b01, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (err_underflow !== 1'b0) begin
      n_errors++; $display("FAIL err_clr_priority: got %0b required 0", err_underflow);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 5; i++) step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd10) begin
      n_errors++; $display("FAIL pre_clear: count=%0d required 10", count);
    end
    step(2'b11, 2'b00, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd0 || overflow !== 1'b0 || status !== EMPTY || rejected_total !== 8'(m_rej)) begin
      n_errors++; $display("FAIL clear: count=%0d ovf=%0b status=%0d rej=%0d required 0/0/0/%0d",
                           count, overflow, status, rejected_total, m_rej);
    end
`ifdef OCC_PEAK_TRACK_EN
    n_checks++;
    if (peak !== 5'd0) begin
      n_errors++; $display("FAIL clear_peak: got %0d required 0", peak);
    end
`endif
  endtask

  task automatic test_reset_mid();
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd17) begin
      n_errors++; $display("FAIL pre_reset: count=%0d required 17", count);
    end
    for (int i = 0; i < 3; i++) begin
      step(2'b11, 2'b00, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (count !== 5'd0 || status !== EMPTY) begin
        n_errors++; $display("FAIL reset_hold[%0d]: count=%0d status=%0d required 0/0", i, count, status);
      end
    end
    step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (count !== 5'd2) begin
      n_errors++; $display("FAIL reset_release: count=%0d required 2", count);
    end
  endtask

  task automatic test_reject_saturation();
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    step(2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 126; i++) begin
      step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
      if (i == 5) begin
        n_checks++;
        if (overflow !== 1'b1) begin
          n_errors++; $display("FAIL consecutive_ovf: got %0b required 1", overflow);
        end
      end
    end
    n_checks++;
    if (rejected_total !== 8'hFE) begin
      n_errors++; $display("FAIL rej_fe: got %0h required fe", rejected_total);
    end
    step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rejected_total !== 8'hFF) begin
      n_errors++; $display("FAIL rej_ff: got %0h required ff", rejected_total);
    end
    step(2'b11, 2'b00, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (rejected_total !== 8'hFF || overflow !== 1'b1) begin
      n_errors++; $display("FAIL rej_hold: rej=%0h ovf=%0b required ff/1", rejected_total, overflow);
    end
  endtask

  task automatic test_random();
    logic [1:0] e, x;
    logic c, ec, r;
    bit fill_phase;
    step(2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      if (i % 60 == 0) fill_phase = ~fill_phase;
      e  = 2'($urandom_range(0, 3));
      x  = 2'($urandom_range(0, 3));
      if (fill_phase) x = x & 2'($urandom_range(0, 3));
      else            e = e & 2'($urandom_range(0, 3));
      c  = ($urandom_range(0, 31) == 0);
      ec = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 127) == 0);
      step(e, x, c, ec, r);
      n_checks++;
      if (count !== 5'(m_count) || status !== exp_status(m_count) || overflow !== m_ovf ||
          rejected_total !== 8'(m_rej) || err_underflow !== m_err) begin
        n_errors++;
        $display("FAIL random[%0d]: count=%0d status=%0d ovf=%0b rej=%0d err=%0b required %0d/%0d/%0b/%0d/%0b",
                 i, count, status, overflow, rejected_total, err_underflow,
                 m_count, exp_status(m_count), m_ovf, m_rej, m_err);
      end
`ifdef OCC_PEAK_TRACK_EN
      n_checks++;
      if (peak !== 5'(m_peak)) begin
        n_errors++; $display("FAIL random_peak[%0d]: got %0d required %0d", i, peak, m_peak);
      end
`endif
    end
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_count = 0; m_rej = 0; m_peak = 0; m_err = 1'b0; m_ovf = 1'b0;
    enter = 2'b00; exit = 2'b00; clear = 1'b0; err_clr = 1'b0; reset = 1'b1;
    test_reset();
    test_fill();
    test_cancel_at_full();
    test_underflow();
    test_clear();
    test_reset_mid();
    test_reject_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lot_occupancy_counter.md
# lot_occupancy_counter

Parametrised parking-lot occupancy counter fed by several entry and exit gates at once. Each cycle it sums the one-cycle enter/exit pulses from all gates and updates a saturating occupancy count in the range 0..CAPACITY. It reports empty/near-full/full status, counts refused entries, and flags impossible exits. It sits between the per-gate sensor FSMs and the display/HEX driver logic.

## Interface
- CAPACITY, 25: maximum occupancy; count saturates here.
- NUM_GATES, 2: number of independent enter/exit pulse pairs.
- NEAR_MARGIN, 3: status is NEAR_FULL when count >= CAPACITY-NEAR_MARGIN and count < CAPACITY.
- REJ_W, 8: width of the rejected-entry total.
- Derived localparam CW = $clog2(CAPACITY+1).
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enter  in  NUM_GATES  one-cycle pulse per car entering, one bit per gate
- exit  in  NUM_GATES  one-cycle pulse per car leaving, one bit per gate
- clear  in  1  synchronous occupancy clear (count and peak only)
- err_clr  in  1  clears err_underflow
- count  out  CW  current occupancy
- status  out  2  lot_status_e: EMPTY, AVAILABLE, NEAR_FULL, FULL
- overflow  out  1  one-cycle pulse: one or more entries were refused
- rejected_total  out  REJ_W  saturating total of refused entries
- err_underflow  out  1  sticky: an exit arrived that would drive count below 0
- peak  out  CW  highest count since reset/clear (only with OCC_PEAK_TRACK_EN)

## Operation
- Per cycle: E = popcount(enter), X = popcount(exit). Compute net = count + E - X as a signed value of width CW+$clog2(NUM_GATES+1)+1, with no truncation before clamping.
- net > CAPACITY: count <= CAPACITY; overflow <= 1; rejected_total += (net-CAPACITY), saturating at all-ones.
- net < 0: count <= 0; err_underflow <= 1 (sticky).
- Otherwise count <= net. Enters and exits in the same cycle cancel. E == X gives no change, including at 0 or CAPACITY.
- Status is a registered FSM derived from next count:
  - EMPTY when 0.
  - FULL when CAPACITY.
  - NEAR_FULL when within NEAR_MARGIN of full.
  - AVAILABLE otherwise.
  - Any state can jump to any other in one cycle, since multiple gates can fire together.
- When NEAR_MARGIN >= CAPACITY, NEAR_FULL covers 1..CAPACITY-1 and AVAILABLE is never produced.
- Priority:
  - reset over everything.
  - clear over enter/exit in the same cycle: pulses that cycle are dropped, no overflow/underflow.
  - err_clr over setting err_underflow in the same cycle: a new underflow then re-sets it on the next event only.
- Reset values: count 0, status EMPTY, overflow 0, rejected_total 0, err_underflow 0, peak 0.
- clear leaves rejected_total and err_underflow unchanged.

## Timing
- All outputs registered. Pulses sampled at edge N are reflected on count/status/overflow after edge N (latency 1 cycle). No extra display-lag stage.
- overflow is high for exactly one cycle per overflowing sample, even on consecutive overflowing cycles.
- Reset asserted mid-operation: all outputs hold reset values from the next edge while reset stays high. The first pulses counted are those sampled at the first edge with reset low.

## Configuration
- OCC_PEAK_TRACK_EN defined: peak port exists. It is updated as peak <= max(peak, next count) in the same cycle as count, and cleared by reset and clear.
- Undefined: the peak port and its register are absent. All other behaviour is identical.

## Structure
- Package lot_pkg holds:
  - typedef enum logic [1:0] lot_status_e {EMPTY=0, AVAILABLE=1, NEAR_FULL=2, FULL=3}.
  - function to derive status from count, CAPACITY and NEAR_MARGIN.
- Sub-module gate_popcount (parameter N): combinational ones-count. Instantiated twice, for enter and exit.

## Test plan
- Reset, then NUM_GATES=2, enter=2'b11 for 13 cycles -> count 2,4,…,24 then 25. Final cycle overflow=1 and rejected_total=1; status NEAR_FULL at 22, FULL at 25.
- At count 25: enter=2'b01, exit=2'b01 together -> count stays 25, overflow 0. Then exit=2'b11 -> 23, status NEAR_FULL.
- At count 1: exit=2'b11 -> count 0, status EMPTY, err_underflow=1 and held. err_clr pulse -> 0.
- At count 10: clear and enter=2'b11 in the same cycle -> count 0, overflow 0, rejected_total unchanged. Peak (if OCC_PEAK_TRACK_EN) 0.
- Reset asserted at count 17 while enter pulses continue -> count 0 and EMPTY the next cycle, held during reset. The first edge after release counts from 0.
- rejected_total at 8'hFE, two refused entries -> 8'hFF; further refusals hold 8'hFF.
